// File: rtl/puf_soc_pkg.sv
// Shared types and helpers for the PUF SoC ring-oscillator pair sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package puf_soc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENABLE  = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } ro_seq_state_t;

    typedef enum logic {
        RO_MANUAL = 1'b0,
        RO_SWEEP  = 1'b1
    } ro_mode_t;

    // Number of unordered pairs (i<j) among n oscillators.
    function automatic int ro_num_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/puf_soc_ro_pair_dec.sv
// Two-select to NUM_RO-bit enable decode; selects >= NUM_RO contribute no bit.
// Latency: combinational.
// Backpressure: none.
module puf_soc_ro_pair_dec
    import puf_soc_pkg::*;
#(
    parameter int NUM_RO = 16,
    parameter int SEL_W  = $clog2(NUM_RO)
) (
    input  logic              en,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    output logic [NUM_RO-1:0] dec
);

    // Only indices 0..NUM_RO-1 are compared, so an out-of-range select
    // (possible when NUM_RO is not a power of two) simply matches nothing.
    always_comb begin
        dec = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            dec[i] = en & ((sel_a == SEL_W'(i)) | (sel_b == SEL_W'(i)));
        end
    end

endmodule

// File: rtl/puf_soc_ro_pair_seq.sv
// RO pair enable generator: manual select decode, or automatic sweep of all i<j pairs.
// Latency: o_puf_en registered, 1 cycle after inputs / state change.
// Backpressure: o_pair_vld held with stable sels until i_pair_rdy; i_abort wins over a handshake.
module puf_soc_ro_pair_seq
    import puf_soc_pkg::*;
#(
    parameter int NUM_RO = 16,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = $clog2(NUM_RO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mode,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_dcod_en,
    input  logic [SEL_W-1:0]  i_sel_mux_0,
    input  logic [SEL_W-1:0]  i_sel_mux_1,
    input  logic [CNT_W-1:0]  i_en_cycles,
    input  logic              i_pair_rdy,
    output logic [NUM_RO-1:0] o_puf_en,
    output logic              o_pair_vld,
    output logic [SEL_W-1:0]  o_pair_sel_0,
    output logic [SEL_W-1:0]  o_pair_sel_1,
    output logic              o_busy,
    output logic              o_sweep_done
);

    // The final pair of a sweep is (NUM_RO-2, NUM_RO-1).
    localparam logic [SEL_W-1:0] LAST_A = SEL_W'(NUM_RO - 2);
    localparam logic [SEL_W-1:0] LAST_B = SEL_W'(NUM_RO - 1);

    ro_seq_state_t     state, state_nxt;
    logic [SEL_W-1:0]  pair_a, pair_a_nxt;
    logic [SEL_W-1:0]  pair_b, pair_b_nxt;
    logic [CNT_W-1:0]  window, window_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  start_window;

    logic              dec_en;
    logic [SEL_W-1:0]  dec_a;
    logic [SEL_W-1:0]  dec_b;
    logic [NUM_RO-1:0] dec_out;

    // A zero-length window would never enable anything; treat it as one cycle.
    assign start_window = (i_en_cycles == '0) ? CNT_W'(1) : i_en_cycles;

    // Next-state, pair advance and window countdown.
    always_comb begin
        state_nxt  = state;
        pair_a_nxt = pair_a;
        pair_b_nxt = pair_b;
        window_nxt = window;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (i_start && (ro_mode_t'(i_mode) == RO_SWEEP)) begin
                    state_nxt  = ENABLE;
                    window_nxt = start_window;
                    cnt_nxt    = start_window;
                    pair_a_nxt = '0;
                    pair_b_nxt = SEL_W'(1);
                end
            end
            ENABLE: begin
                if (i_abort) begin
                    state_nxt  = IDLE;
                    pair_a_nxt = '0;
                    pair_b_nxt = '0;
                end else if (cnt <= CNT_W'(1)) begin
                    state_nxt = PRESENT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            PRESENT: begin
                if (i_abort) begin
                    state_nxt  = IDLE;
                    pair_a_nxt = '0;
                    pair_b_nxt = '0;
                end else if (i_pair_rdy) begin
                    if ((pair_a == LAST_A) && (pair_b == LAST_B)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ENABLE;
                        cnt_nxt   = window;
                        if (pair_b == LAST_B) begin
                            pair_a_nxt = pair_a + SEL_W'(1);
                            pair_b_nxt = pair_a + SEL_W'(2);
                        end else begin
                            pair_b_nxt = pair_b + SEL_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_nxt  = IDLE;
                pair_a_nxt = '0;
                pair_b_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Steer the shared decoder: sweep pair while enabling, manual selects only
    // when staying idle; returning to idle forces one all-zero cycle.
    always_comb begin
        dec_en = 1'b0;
        dec_a  = pair_a_nxt;
        dec_b  = pair_b_nxt;
        if (state_nxt == ENABLE) begin
            dec_en = 1'b1;
        end else if ((state == IDLE) && (state_nxt == IDLE)) begin
            dec_en = i_dcod_en;
            dec_a  = i_sel_mux_0;
            dec_b  = i_sel_mux_1;
        end
    end

    puf_soc_ro_pair_dec #(
        .NUM_RO (NUM_RO),
        .SEL_W  (SEL_W)
    ) u_dec (
        .en    (dec_en),
        .sel_a (dec_a),
        .sel_b (dec_b),
        .dec   (dec_out)
    );

    // State, pair, window and registered enable vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pair_a   <= '0;
            pair_b   <= '0;
            window   <= '0;
            cnt      <= '0;
            o_puf_en <= '0;
        end else begin
            state    <= state_nxt;
            pair_a   <= pair_a_nxt;
            pair_b   <= pair_b_nxt;
            window   <= window_nxt;
            cnt      <= cnt_nxt;
            o_puf_en <= dec_out;
        end
    end

    assign o_pair_vld   = (state == PRESENT);
    assign o_pair_sel_0 = pair_a;
    assign o_pair_sel_1 = pair_b;
    assign o_busy       = (state == ENABLE) || (state == PRESENT);
    assign o_sweep_done = (state == DONE);

endmodule

// File: tb/tb_puf_soc_ro_pair_seq.sv
// Bench for the RO pair sequencer: manual decode tables, sweep checker, corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_puf_soc_ro_pair_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // 16-RO instance: manual decode
    logic        m16_mode, m16_start, m16_abort, m16_dcod, m16_rdy;
    logic [3:0]  m16_s0, m16_s1, m16_p0, m16_p1;
    logic [15:0] m16_enc, m16_en;
    logic        m16_vld, m16_busy, m16_done;

    // 4-RO instance: sweeps
    logic        s4_mode, s4_start, s4_abort, s4_dcod, s4_rdy;
    logic [1:0]  s4_s0, s4_s1, s4_p0, s4_p1;
    logic [15:0] s4_enc;
    logic [3:0]  s4_en;
    logic        s4_vld, s4_busy, s4_done;

    // 5-RO instance: out-of-range selects
    logic        g5_mode, g5_start, g5_abort, g5_dcod, g5_rdy;
    logic [2:0]  g5_s0, g5_s1, g5_p0, g5_p1;
    logic [15:0] g5_enc;
    logic [4:0]  g5_en;
    logic        g5_vld, g5_busy, g5_done;

    puf_soc_ro_pair_seq dut16 (
        .clk(clk), .rst(rst), .i_mode(m16_mode), .i_start(m16_start), .i_abort(m16_abort),
        .i_dcod_en(m16_dcod), .i_sel_mux_0(m16_s0), .i_sel_mux_1(m16_s1), .i_en_cycles(m16_enc),
        .i_pair_rdy(m16_rdy), .o_puf_en(m16_en), .o_pair_vld(m16_vld), .o_pair_sel_0(m16_p0),
        .o_pair_sel_1(m16_p1), .o_busy(m16_busy), .o_sweep_done(m16_done)
    );

    puf_soc_ro_pair_seq #(.NUM_RO(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .i_mode(s4_mode), .i_start(s4_start), .i_abort(s4_abort),
        .i_dcod_en(s4_dcod), .i_sel_mux_0(s4_s0), .i_sel_mux_1(s4_s1), .i_en_cycles(s4_enc),
        .i_pair_rdy(s4_rdy), .o_puf_en(s4_en), .o_pair_vld(s4_vld), .o_pair_sel_0(s4_p0),
        .o_pair_sel_1(s4_p1), .o_busy(s4_busy), .o_sweep_done(s4_done)
    );

    puf_soc_ro_pair_seq #(.NUM_RO(5), .CNT_W(16)) dut5 (
        .clk(clk), .rst(rst), .i_mode(g5_mode), .i_start(g5_start), .i_abort(g5_abort),
        .i_dcod_en(g5_dcod), .i_sel_mux_0(g5_s0), .i_sel_mux_1(g5_s1), .i_en_cycles(g5_enc),
        .i_pair_rdy(g5_rdy), .o_puf_en(g5_en), .o_pair_vld(g5_vld), .o_pair_sel_0(g5_p0),
        .o_pair_sel_1(g5_p1), .o_busy(g5_busy), .o_sweep_done(g5_done)
    );

    typedef struct {
        logic        en;
        int          s0;
        int          s1;
        logic [15:0] exp;
    } mvec_t;

    typedef struct {
        int a;
        int b;
    } pair_t;

    mvec_t tab16 [6];
    mvec_t tab5  [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode: a bit per in-range select, nothing when disabled.
    function automatic int ref_dec(input int n, input bit en, input int s0, input int s1);
        int r;
        r = 0;
        if (en) begin
            if (s0 < n) r = r | (1 << s0);
            if (s1 < n) r = r | (1 << s1);
        end
        return r;
    endfunction

    task automatic man16(input logic en, input int s0, input int s1, output logic [15:0] got);
        @(negedge clk);
        m16_dcod = en;
        m16_s0   = 4'(s0);
        m16_s1   = 4'(s1);
        @(posedge clk);
        #1 got = m16_en;
    endtask

    task automatic man5(input logic en, input int s0, input int s1, output logic [4:0] got);
        @(negedge clk);
        g5_dcod = en;
        g5_s0   = 3'(s0);
        g5_s1   = 3'(s1);
        @(posedge clk);
        #1 got = g5_en;
    endtask

    // Run one full sweep on the 4-RO instance and check it cycle by cycle
    // against the list of expected pairs and the requested window length.
    task automatic sweep4(input logic [15:0] win_in, input int rdy_pct, input int stall_pair,
                          input bit poke);
        pair_t q[$];
        int    w, idx, run, stall, cyc, budget, e;
        bit    inpres, fin;
        q = {};
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                q.push_back('{i, j});
        w = (win_in == 16'd0) ? 1 : int'(win_in);
        @(negedge clk);
        s4_mode  = 1'b1;
        s4_start = 1'b1;
        s4_enc   = win_in;
        s4_rdy   = 1'b0;
        @(negedge clk);
        s4_start = 1'b0;
        s4_enc   = 16'd9;
        s4_mode  = 1'($urandom);
        idx = 0; run = 0; stall = 0; inpres = 0; fin = 0; e = 0;
        budget = q.size() * (w + 12) + 40;
        for (cyc = 0; cyc < budget && !fin; cyc++) begin
            if (s4_done) begin
                chk("done_after_last", 32'(idx), 32'(puf_soc_pkg::ro_num_pairs(4)));
                chk("done_busy", 32'(s4_busy), 32'd0);
                chk("done_quiet", 32'({s4_vld, s4_en}), 32'd0);
                fin = 1;
            end else begin
                chk("busy", 32'(s4_busy), 32'd1);
                if (idx >= q.size()) begin
                    chk("pair_overrun", 32'(idx), 32'(q.size() - 1));
                    fin = 1;
                end else if (s4_en != 4'd0) begin
                    chk("vld_during_en", 32'(s4_vld), 32'd0);
                    e = (1 << q[idx].a) | (1 << q[idx].b);
                    chk("en_vec", 32'(s4_en), 32'(e));
                    run++;
                end else if (s4_vld) begin
                    if (!inpres) begin
                        chk("window_len", 32'(run), 32'(w));
                        inpres = 1;
                        run    = 0;
                    end
                    chk("sel_a", 32'(s4_p0), 32'(q[idx].a));
                    chk("sel_b", 32'(s4_p1), 32'(q[idx].b));
                    if (idx == stall_pair && stall < 5) begin
                        s4_rdy = 1'b0;
                        stall++;
                    end else begin
                        s4_rdy = (int'($urandom_range(99)) < rdy_pct);
                    end
                    if (s4_rdy) begin
                        idx++;
                        inpres = 0;
                    end
                end else begin
                    chk("busy_gap_vld", 32'(s4_vld), 32'd1);
                end
            end
            if (poke && cyc == 5) begin
                s4_start = 1'b1;
                s4_mode  = 1'b1;
                s4_enc   = 16'd7;
            end else begin
                s4_start = 1'b0;
            end
            @(negedge clk);
        end
        chk("sweep_finished", 32'(fin), 32'd1);
        chk("done_single", 32'(s4_done), 32'd0);
        chk("idle_after", 32'(s4_busy), 32'd0);
        s4_rdy = 1'b0;
    endtask

    initial begin
        logic [15:0] g16;
        logic [4:0]  g5;
        int          odd, found;

        tab16[0] = '{1'b1, 3, 3, 16'h0008};
        tab16[1] = '{1'b1, 2, 5, 16'h0024};
        tab16[2] = '{1'b0, 2, 5, 16'h0000};
        tab16[3] = '{1'b1, 0, 15, 16'h8001};
        tab16[4] = '{1'b1, 15, 15, 16'h8000};
        tab16[5] = '{1'b1, 0, 0, 16'h0001};
        tab5[0]  = '{1'b1, 5, 5, 16'h0000};
        tab5[1]  = '{1'b1, 7, 1, 16'h0002};
        tab5[2]  = '{1'b1, 4, 6, 16'h0010};
        tab5[3]  = '{1'b1, 0, 4, 16'h0011};
        tab5[4]  = '{1'b0, 0, 4, 16'h0000};

        rst = 1'b1;
        m16_mode = 0; m16_start = 0; m16_abort = 0; m16_dcod = 0; m16_rdy = 0;
        m16_s0 = 0; m16_s1 = 0; m16_enc = 0;
        s4_mode = 0; s4_start = 0; s4_abort = 0; s4_dcod = 0; s4_rdy = 0;
        s4_s0 = 0; s4_s1 = 0; s4_enc = 0;
        g5_mode = 0; g5_start = 0; g5_abort = 0; g5_dcod = 0; g5_rdy = 0;
        g5_s0 = 0; g5_s1 = 0; g5_enc = 0;
        #1;
        chk("rst_m16", 32'({m16_en, m16_vld, m16_p0, m16_p1, m16_busy, m16_done}), 32'd0);
        chk("rst_s4", 32'({s4_en, s4_vld, s4_p0, s4_p1, s4_busy, s4_done}), 32'd0);
        chk("rst_g5", 32'({g5_en, g5_vld, g5_p0, g5_p1, g5_busy, g5_done}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Manual decode tables
        for (int k = 0; k < 6; k++) begin
            man16(tab16[k].en, tab16[k].s0, tab16[k].s1, g16);
            chk($sformatf("man16_tab%0d", k), 32'(g16), 32'(tab16[k].exp));
        end
        for (int k = 0; k < 5; k++) begin
            man5(tab5[k].en, tab5[k].s0, tab5[k].s1, g5);
            chk($sformatf("man5_tab%0d", k), 32'(g5), 32'(tab5[k].exp[4:0]));
        end

        // All 256 select combinations: only equal selects give odd parity
        odd = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                man16(1'b1, a, b, g16);
                chk("man16_all", 32'(g16), 32'(ref_dec(16, 1'b1, a, b)));
                if (^g16) odd++;
            end
        end
        chk("odd_parity_count", 32'(odd), 32'd16);

        // Random manual vectors
        for (int k = 0; k < 40; k++) begin
            int  a, b;
            logic en;
            a  = int'($urandom_range(15));
            b  = int'($urandom_range(15));
            en = 1'($urandom);
            man16(en, a, b, g16);
            chk("man16_rand", 32'(g16), 32'(ref_dec(16, en, a, b)));
        end
        m16_dcod = 1'b0;

        // Start with manual mode selected does not begin a sweep
        @(negedge clk);
        s4_mode = 1'b0; s4_start = 1'b1; s4_enc = 16'd2;
        s4_dcod = 1'b1; s4_s0 = 2'd0; s4_s1 = 2'd2;
        @(negedge clk);
        s4_start = 1'b0;
        chk("manual_start_busy", 32'(s4_busy), 32'd0);
        chk("manual_start_en", 32'(s4_en), 32'h5);
        s4_dcod = 1'b0;

        // Sweeps: nominal, backpressure, zero window with a stray start, random
        sweep4(16'd2, 100, -1, 1'b0);
        sweep4(16'd2, 100, 1, 1'b0);
        sweep4(16'd0, 100, -1, 1'b1);
        for (int r = 0; r < 3; r++)
            sweep4(16'($urandom_range(3)), 60, int'($urandom_range(5)), 1'b0);

        // Abort during the enable window of pair (1,2)
        @(negedge clk);
        s4_mode = 1'b1; s4_start = 1'b1; s4_enc = 16'd3; s4_rdy = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (s4_en == 4'b0110) found = 1;
            else @(negedge clk);
        end
        chk("abort_reach_pair12", 32'(found), 32'd1);
        s4_abort = 1'b1;
        @(negedge clk);
        s4_abort = 1'b0;
        chk("abort_busy", 32'(s4_busy), 32'd0);
        chk("abort_en", 32'(s4_en), 32'd0);
        chk("abort_vld", 32'(s4_vld), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_done", 32'(s4_done), 32'd0);
            @(negedge clk);
        end
        s4_start = 1'b1; s4_enc = 16'd1;
        @(negedge clk);
        s4_start = 1'b0;
        chk("restart_en", 32'(s4_en), 32'h3);
        chk("restart_sel", 32'({s4_p0, s4_p1}), 32'h1);
        s4_abort = 1'b1;
        @(negedge clk);
        s4_abort = 1'b0;
        s4_rdy   = 1'b0;

        // Asynchronous reset while presenting a pair
        @(negedge clk);
        s4_mode = 1'b1; s4_start = 1'b1; s4_enc = 16'd2;
        @(negedge clk);
        s4_start = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (s4_vld) found = 1;
            else @(negedge clk);
        end
        chk("rst_reach_present", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", 32'({s4_en, s4_vld, s4_p0, s4_p1, s4_busy, s4_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        s4_dcod = 1'b1; s4_s0 = 2'd1; s4_s1 = 2'd3;
        @(posedge clk);
        #1;
        chk("post_rst_manual", 32'(s4_en), 32'hA);
        chk("post_rst_idle", 32'(s4_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/puf_soc_ro_pair_seq.md
Name: puf_soc_ro_pair_seq

Overview:
Ring-oscillator (RO) pair enable generator for the PUF SoC.
- Manual mode: registered decode of two RO selects into an enable vector.
- Sweep mode: steps automatically through every unordered RO pair (i<j). For each pair it holds an enable window of programmable length, then hands the pair indices to the downstream frequency-compare logic over a valid/ready handshake.
- Sits between the SoC control registers and the RO array / counter block.

Parameters:
- NUM_RO, 16, number of ring oscillators (>=2; power of two not required).
- CNT_W, 16, width of the enable-window cycle counter.
- SEL_W, $clog2(NUM_RO), width of the RO select fields (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- i_mode  in  1  0 = manual decode, 1 = sweep; sampled only on an accepted i_start.
- i_start  in  1  one-cycle pulse; starts a sweep when idle and i_mode=1.
- i_abort  in  1  terminates a sweep in progress.
- i_dcod_en  in  1  manual-mode decode enable.
- i_sel_mux_0  in  SEL_W  manual-mode RO select A.
- i_sel_mux_1  in  SEL_W  manual-mode RO select B.
- i_en_cycles  in  CNT_W  enable-window length in cycles; sampled on an accepted i_start.
- i_pair_rdy  in  1  downstream ready.
- o_puf_en  out  NUM_RO  RO enable vector.
- o_pair_vld  out  1  pair indices valid.
- o_pair_sel_0  out  SEL_W  pair index A (lower).
- o_pair_sel_1  out  SEL_W  pair index B (higher).
- o_busy  out  1  sweep in progress.
- o_sweep_done  out  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Reset (asynchronous): all outputs 0; FSM to IDLE; counters cleared.
- FSM states: IDLE, ENABLE, PRESENT, DONE.
- Manual mode (FSM in IDLE):
  - o_puf_en registered with 1-cycle latency: onehot(i_sel_mux_0) | onehot(i_sel_mux_1) when i_dcod_en=1, else 0.
  - Equal selects give a single bit set (odd parity); distinct selects give two bits (even parity).
  - A select >= NUM_RO contributes no bit.
- IDLE -> ENABLE on i_start=1 with i_mode=1:
  - Latch window = max(i_en_cycles, 1).
  - Pair := (0,1); o_busy=1 from the next cycle.
- ENABLE:
  - o_puf_en = onehot(A)|onehot(B) for exactly window cycles.
  - o_pair_vld=0 throughout.
  - On the last cycle -> PRESENT.
- PRESENT:
  - o_puf_en=0; o_pair_vld=1; sels hold stable until handshake.
  - o_pair_vld is never dropped without a handshake.
  - On vld&rdy: if pair is (NUM_RO-2, NUM_RO-1) -> DONE; otherwise advance and -> ENABLE next cycle.
  - Advance order: B+1; if B wraps past NUM_RO-1, then A+1 and B=A+2.
  - Total pairs per sweep = NUM_RO*(NUM_RO-1)/2 (120 at default).
- DONE: o_sweep_done=1 for one cycle; o_busy=0; -> IDLE.
- While o_busy=1:
  - i_start, i_mode, i_en_cycles and the manual inputs are ignored.
  - o_puf_en is driven only by the sweep.
- i_abort, in any busy state, takes priority over a same-cycle handshake:
  - Next cycle: IDLE; o_puf_en, o_pair_vld, o_busy = 0.
  - No o_sweep_done pulse.
- i_abort in IDLE has no effect.
- Window counter: CNT_W bits, counts down, no wrap; i_en_cycles=0 is treated as 1.

Decomposition:
- Package puf_soc_pkg holds:
  - Enum ro_seq_state_t {IDLE, ENABLE, PRESENT, DONE}.
  - Enum ro_mode_t {RO_MANUAL, RO_SWEEP}.
  - Function ro_num_pairs(n) = n*(n-1)/2.
- One sub-module, puf_soc_ro_pair_dec: combinational two-select to NUM_RO-bit decode, with an out-of-range guard. It is shared by the manual and sweep paths.

Test Plan:
- Manual, NUM_RO=16: i_dcod_en=1, sel 3/3 -> o_puf_en=16'h0008 one cycle later; sel 2/5 -> 16'h0024; i_dcod_en=0 -> 16'h0000. All 256 combos give exactly 16 odd-parity results.
- Sweep, NUM_RO=4, i_en_cycles=2, i_pair_rdy=1:
  - Pairs in order (0,1)(0,2)(0,3)(1,2)(1,3)(2,3).
  - Each pair: o_puf_en two bits high for exactly 2 cycles, then 1 o_pair_vld cycle.
  - One o_sweep_done pulse; o_busy high throughout.
- Backpressure: i_pair_rdy=0 for 5 cycles during PRESENT -> o_pair_vld and sels stable, o_puf_en=0; advance only on the cycle rdy rises.
- i_en_cycles=0 -> each window is 1 cycle; i_start pulsed mid-sweep -> ignored; pair count still 6.
- i_abort during ENABLE of pair (1,2) -> next cycle o_busy=0, o_puf_en=0, no done pulse. A new i_start restarts from (0,1).
- rst asserted mid-PRESENT -> outputs 0 immediately (asynchronous); after release, IDLE, and manual decode works.
